phy_mgmt_sequencer: RTL and testbench

PHY_MGMT_SEQUENCER -- requirements
Module: phy_mgmt_sequencer

---
 rtl/phy_mgmt_pkg.sv | 49 ++++
 rtl/phy_mgmt_timer.sv | 30 +++
 rtl/phy_mgmt_sequencer.sv | 226 ++++++++++++++++++++++
 tb/tb_phy_mgmt_sequencer.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/phy_mgmt_pkg.sv
// Shared definitions for the PHY management sequencer: FSM and transaction
// encodings, the power-on init table, and the status register layout.
package phy_mgmt_pkg;

  typedef enum logic [2:0] {
    ST_POWERUP,
    ST_DISPATCH,
    ST_ISSUE,
    ST_BUSY,
    ST_DONE
  } state_e;

  typedef enum logic [1:0] {
    TXN_INIT,
    TXN_HOST_RD,
    TXN_HOST_WR,
    TXN_POLL
  } txn_e;

  typedef struct packed {
    logic [4:0]  addr;
    logic [15:0] data;
  } init_entry_t;

  localparam int INIT_COUNT = 2;
  localparam int INIT_IDX_W = $clog2(INIT_COUNT + 1);

  localparam logic [4:0] STATUS_REG = 5'd17;
  localparam int         LINK_BIT   = 10;
  localparam int         SPEED_HI   = 9;
  localparam int         SPEED_LO   = 8;

  localparam logic [1:0] SPEED_10   = 2'b00;
  localparam logic [1:0] SPEED_100  = 2'b01;
  localparam logic [1:0] SPEED_1000 = 2'b10;
  localparam logic [1:0] SPEED_RSVD = 2'b11;

  function automatic init_entry_t init_entry(input logic [INIT_IDX_W-1:0] idx);
    init_entry_t e;
    e = '{addr: 5'd0, data: 16'h0000};
    case (idx)
      INIT_IDX_W'(0): e = '{addr: 5'd0, data: 16'h1140};
      INIT_IDX_W'(1): e = '{addr: 5'd4, data: 16'h01E1};
      default: ;
    endcase
    return e;
  endfunction

endpackage

// File: rtl/phy_mgmt_timer.sv
// Loadable down-counter with a zero flag. Stops at zero.
//   clock, reset_n : clock / async active-low reset (count clears to 0)
//   load_i         : load load_val_i this cycle (wins over counting)
//   load_val_i     : value to load
//   zero_o         : counter is at zero
module phy_mgmt_timer #(
  parameter int WIDTH = 18
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  output logic             zero_o
);

  logic [WIDTH-1:0] count_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= load_val_i;
    end else if (count_q != '0) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign zero_o = (count_q == '0);

endmodule

// File: rtl/phy_mgmt_sequencer.sv
// PHY management sequencer: after power-up delay writes the init table,
// then serves host MDIO requests and periodically polls the PHY status.
//   clock, reset_n              : clock / async active-low reset
//   host_rd_req/host_wr_req     : level host request, held until host_ack
//   host_addr, host_wr_data     : host register address / write data
//   host_ack, host_rd_data      : one-cycle completion pulse / read result
//   mdio_*                      : request interface to the MDIO engine
//   init_done, link_up, speed   : init/status results
//   status_valid, timeout_err   : first poll completed / sticky timeout
//
// state    | meaning
// POWERUP  | waiting out the power-up delay
// DISPATCH | choosing the next transaction (init > host > poll)
// ISSUE    | request asserted, waiting for engine to go busy
// BUSY     | request dropped, waiting for engine to go idle
// DONE     | one-cycle completion: ack host / advance init / restart poll
module phy_mgmt_sequencer
  import phy_mgmt_pkg::*;
#(
  parameter int POWERUP_CYCLES = 250000,
  parameter int POLL_CYCLES    = 250000,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        host_rd_req,
  input  logic        host_wr_req,
  input  logic [4:0]  host_addr,
  input  logic [15:0] host_wr_data,
  output logic        host_ack,
  output logic [15:0] host_rd_data,
  output logic [4:0]  mdio_addr,
  output logic [15:0] mdio_wr_data,
  output logic        mdio_rd_req,
  output logic        mdio_wr_req,
  input  logic        mdio_ready,
  input  logic [15:0] mdio_rd_data,
  output logic        init_done,
  output logic        link_up,
  output logic [1:0]  speed,
  output logic        status_valid,
  output logic        timeout_err
);

  // Load values are trimmed so that the observed spacing equals the
  // parameter: power-up covers the arming cycle plus DISPATCH, the poll
  // reload covers the DONE and DISPATCH cycles, and the timeout covers the
  // ISSUE entry cycle.
  localparam int PU_W  = $clog2(POWERUP_CYCLES + 1);
  localparam int PL_W  = $clog2(POLL_CYCLES + 1);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [PU_W-1:0] PU_LOAD = PU_W'((POWERUP_CYCLES >= 2) ? POWERUP_CYCLES - 2 : 0);
  localparam logic [PL_W-1:0] PL_LOAD = PL_W'((POLL_CYCLES >= 2) ? POLL_CYCLES - 2 : 0);
  localparam logic [TO_W-1:0] TO_LOAD = TO_W'((TIMEOUT_CYCLES >= 1) ? TIMEOUT_CYCLES - 1 : 0);

  state_e                  state_q, state_d;
  txn_e                    kind_q, kind_d;
  logic [4:0]              addr_q, addr_d;
  logic [15:0]             wdata_q, wdata_d;
  logic [INIT_IDX_W-1:0]   init_idx_q, init_idx_d;
  logic                    init_done_q, init_done_d;
  logic                    pu_armed_q, pu_armed_d;
  logic [15:0]             host_rd_data_q, host_rd_data_d;
  logic                    link_up_q, link_up_d;
  logic [1:0]              speed_q, speed_d;
  logic                    status_valid_q, status_valid_d;
  logic                    timeout_err_q, timeout_err_d;

  logic        pu_load, pl_load, to_load;
  logic        pu_zero, pl_zero, to_zero;
  logic        enter_done, abort;
  logic [1:0]  raw_speed;
  init_entry_t entry;

  phy_mgmt_timer #(.WIDTH(PU_W)) u_pu_timer (
    .clock(clock), .reset_n(reset_n), .load_i(pu_load), .load_val_i(PU_LOAD), .zero_o(pu_zero));
  phy_mgmt_timer #(.WIDTH(PL_W)) u_poll_timer (
    .clock(clock), .reset_n(reset_n), .load_i(pl_load), .load_val_i(PL_LOAD), .zero_o(pl_zero));
  phy_mgmt_timer #(.WIDTH(TO_W)) u_to_timer (
    .clock(clock), .reset_n(reset_n), .load_i(to_load), .load_val_i(TO_LOAD), .zero_o(to_zero));

  always_comb begin
    state_d        = state_q;
    kind_d         = kind_q;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    init_idx_d     = init_idx_q;
    init_done_d    = init_done_q;
    pu_armed_d     = pu_armed_q;
    host_rd_data_d = host_rd_data_q;
    link_up_d      = link_up_q;
    speed_d        = speed_q;
    status_valid_d = status_valid_q;
    timeout_err_d  = timeout_err_q;
    pu_load        = 1'b0;
    pl_load        = 1'b0;
    to_load        = 1'b0;
    enter_done     = 1'b0;
    abort          = 1'b0;
    entry          = init_entry(init_idx_q);
    raw_speed      = mdio_rd_data[SPEED_HI:SPEED_LO];

    case (state_q)
      ST_POWERUP: begin
        if (!pu_armed_q) begin
          pu_load    = 1'b1;
          pu_armed_d = 1'b1;
        end else if (pu_zero) begin
          state_d = ST_DISPATCH;
        end
      end
      ST_DISPATCH: begin
        if (mdio_ready) begin
          if (!init_done_q) begin
            kind_d  = TXN_INIT;
            addr_d  = entry.addr;
            wdata_d = entry.data;
            state_d = ST_ISSUE;
          end else if (host_rd_req) begin
            kind_d  = TXN_HOST_RD;
            addr_d  = host_addr;
            wdata_d = host_wr_data;
            state_d = ST_ISSUE;
          end else if (host_wr_req) begin
            kind_d  = TXN_HOST_WR;
            addr_d  = host_addr;
            wdata_d = host_wr_data;
            state_d = ST_ISSUE;
          end else if (pl_zero) begin
            kind_d  = TXN_POLL;
            addr_d  = STATUS_REG;
            wdata_d = 16'h0000;
            state_d = ST_ISSUE;
          end
          to_load = (state_d == ST_ISSUE);
        end
      end
      ST_ISSUE: begin
        if (!mdio_ready) begin
          state_d = ST_BUSY;
        end else if (to_zero) begin
          abort = 1'b1;
        end
      end
      ST_BUSY: begin
        if (mdio_ready) begin
          enter_done = 1'b1;
        end else if (to_zero) begin
          abort = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_DISPATCH;
        if (kind_q == TXN_INIT) begin
          init_idx_d  = init_idx_q + 1'b1;
          init_done_d = (int'(init_idx_q) + 1 == INIT_COUNT);
        end
        if (kind_q == TXN_POLL) begin
          pl_load = 1'b1;
        end
      end
      default: state_d = ST_POWERUP;
    endcase

    // Results are captured on the way into DONE so they are already
    // visible while host_ack is high.
    if (abort) begin
      timeout_err_d = 1'b1;
      enter_done    = 1'b1;
    end
    if (enter_done) begin
      state_d = ST_DONE;
      if (kind_q == TXN_HOST_RD) begin
        host_rd_data_d = abort ? 16'hFFFF : mdio_rd_data;
      end
      if (kind_q == TXN_POLL && !abort) begin
        link_up_d      = mdio_rd_data[LINK_BIT];
        speed_d        = (raw_speed == SPEED_RSVD) ? SPEED_10 : raw_speed;
        status_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= ST_POWERUP;
      kind_q         <= TXN_INIT;
      addr_q         <= 5'd0;
      wdata_q        <= 16'h0000;
      init_idx_q     <= '0;
      init_done_q    <= 1'b0;
      pu_armed_q     <= 1'b0;
      host_rd_data_q <= 16'h0000;
      link_up_q      <= 1'b0;
      speed_q        <= SPEED_10;
      status_valid_q <= 1'b0;
      timeout_err_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      kind_q         <= kind_d;
      addr_q         <= addr_d;
      wdata_q        <= wdata_d;
      init_idx_q     <= init_idx_d;
      init_done_q    <= init_done_d;
      pu_armed_q     <= pu_armed_d;
      host_rd_data_q <= host_rd_data_d;
      link_up_q      <= link_up_d;
      speed_q        <= speed_d;
      status_valid_q <= status_valid_d;
      timeout_err_q  <= timeout_err_d;
    end
  end

  assign mdio_rd_req  = (state_q == ST_ISSUE) && (kind_q == TXN_HOST_RD || kind_q == TXN_POLL);
  assign mdio_wr_req  = (state_q == ST_ISSUE) && (kind_q == TXN_INIT || kind_q == TXN_HOST_WR);
  assign mdio_addr    = addr_q;
  assign mdio_wr_data = wdata_q;
  assign host_ack     = (state_q == ST_DONE) && (kind_q == TXN_HOST_RD || kind_q == TXN_HOST_WR);
  assign host_rd_data = host_rd_data_q;
  assign init_done    = init_done_q;
  assign link_up      = link_up_q;
  assign speed        = speed_q;
  assign status_valid = status_valid_q;
  assign timeout_err  = timeout_err_q;

endmodule

// File: tb/tb_phy_mgmt_sequencer.sv
// Directed bench for phy_mgmt_sequencer with a small MDIO engine model.
// Cycle numbering: cycle 0 is the first rising edge with reset_n high;
// all sampling is done on the falling edge.
module tb_phy_mgmt_sequencer;

  logic        clock;
  logic        reset_n;
  logic        host_rd_req, host_wr_req;
  logic [4:0]  host_addr;
  logic [15:0] host_wr_data;
  logic        host_ack;
  logic [15:0] host_rd_data;
  logic [4:0]  mdio_addr;
  logic [15:0] mdio_wr_data;
  logic        mdio_rd_req, mdio_wr_req;
  logic        mdio_ready;
  logic [15:0] mdio_rd_data;
  logic        init_done, link_up, status_valid, timeout_err;
  logic [1:0]  speed;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc;

  // engine model state
  logic        eng_rdy;
  logic [1:0]  eng_cnt;
  logic [4:0]  lat_addr;
  logic [15:0] lat_wdata;
  logic [15:0] mdl_regs [32];
  int          unstable;
  logic        stuck, hold_low;

  phy_mgmt_sequencer #(
    .POWERUP_CYCLES(16), .POLL_CYCLES(64), .TIMEOUT_CYCLES(256)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .host_rd_req(host_rd_req), .host_wr_req(host_wr_req),
    .host_addr(host_addr), .host_wr_data(host_wr_data),
    .host_ack(host_ack), .host_rd_data(host_rd_data),
    .mdio_addr(mdio_addr), .mdio_wr_data(mdio_wr_data),
    .mdio_rd_req(mdio_rd_req), .mdio_wr_req(mdio_wr_req),
    .mdio_ready(mdio_ready), .mdio_rd_data(mdio_rd_data),
    .init_done(init_done), .link_up(link_up), .speed(speed),
    .status_valid(status_valid), .timeout_err(timeout_err)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) cyc <= -1;
    else          cyc <= cyc + 1;
  end

  assign mdio_ready = eng_rdy && !hold_low;

  // Accept a request, stay busy for three cycles, then return read data.
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      eng_rdy      <= 1'b1;
      eng_cnt      <= 2'd0;
      lat_addr     <= 5'd0;
      lat_wdata    <= 16'h0;
      mdio_rd_data <= 16'h0;
      unstable     <= 0;
      for (int i = 0; i < 32; i++) mdl_regs[i] <= 16'h0;
      mdl_regs[2]  <= 16'h0022;
      mdl_regs[17] <= 16'h0600;
    end else if (eng_rdy) begin
      if (mdio_ready && !stuck && (mdio_rd_req || mdio_wr_req)) begin
        eng_rdy   <= 1'b0;
        eng_cnt   <= 2'd2;
        lat_addr  <= mdio_addr;
        lat_wdata <= mdio_wr_data;
        if (mdio_wr_req) mdl_regs[mdio_addr] <= mdio_wr_data;
      end
    end else if (eng_cnt != 2'd0) begin
      eng_cnt <= eng_cnt - 2'd1;
    end else begin
      eng_rdy      <= 1'b1;
      mdio_rd_data <= mdl_regs[lat_addr];
      if (mdio_addr !== lat_addr || mdio_wr_data !== lat_wdata) unstable <= unstable + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic sig(input int sel);
    case (sel)
      0: return mdio_wr_req;
      1: return mdio_rd_req;
      2: return mdio_ready;
      3: return host_ack;
      4: return status_valid;
      default: return mdio_rd_req || mdio_wr_req;
    endcase
  endfunction

  task automatic wait_sig(input int sel, input logic lvl, input string tag);
    int n = 0;
    while (sig(sel) !== lvl && n < 2000) begin
      @(negedge clock);
      n++;
    end
    chk(tag, (n < 2000), 1);
  endtask

  initial begin
    int d, n, bad;
    reset_n = 1'b0; host_rd_req = 1'b0; host_wr_req = 1'b0;
    host_addr = 5'd0; host_wr_data = 16'h0; stuck = 1'b0; hold_low = 1'b0;
    repeat (3) @(negedge clock);
    chk("rst_init_done", init_done, 0);
    chk("rst_link_up", link_up, 0);
    chk("rst_speed", speed, 0);
    chk("rst_status_valid", status_valid, 0);
    chk("rst_timeout_err", timeout_err, 0);
    chk("rst_host_ack", host_ack, 0);
    chk("rst_host_rd_data", host_rd_data, 16'h0000);
    chk("rst_reqs", {mdio_rd_req, mdio_wr_req}, 0);
    reset_n = 1'b1;

    // host read raised during power-up must wait for init
    repeat (5) @(negedge clock);
    host_rd_req = 1'b1; host_addr = 5'd2;
    wait_sig(0, 1'b1, "wr0_seen");
    chk("wr0_cycle", cyc, 16);
    chk("wr0_addr", mdio_addr, 5'd0);
    chk("wr0_data", mdio_wr_data, 16'h1140);
    wait_sig(0, 1'b0, "wr0_drop");
    wait_sig(0, 1'b1, "wr1_seen");
    chk("wr1_addr", mdio_addr, 5'd4);
    chk("wr1_data", mdio_wr_data, 16'h01E1);
    chk("wr1_no_rd", mdio_rd_req, 0);
    wait_sig(2, 1'b0, "wr1_busy");
    wait_sig(2, 1'b1, "wr1_idle");
    @(negedge clock);
    chk("init_done_in_done", init_done, 0);
    @(negedge clock);
    chk("init_done_after", init_done, 1);

    wait_sig(1, 1'b1, "host_rd_issue");
    chk("host_rd_addr", mdio_addr, 5'd2);
    wait_sig(3, 1'b1, "host_rd_ack");
    chk("host_rd_data", host_rd_data, 16'h0022);
    host_rd_req = 1'b0;
    @(negedge clock);
    chk("host_ack_one_cycle", host_ack, 0);

    // first poll then spacing to the second
    wait_sig(1, 1'b1, "poll1_issue");
    chk("poll1_addr", mdio_addr, 5'd17);
    wait_sig(4, 1'b1, "poll1_done");
    d = cyc;
    chk("poll1_link", link_up, 1);
    chk("poll1_speed", speed, 2'b10);
    wait_sig(1, 1'b1, "poll2_issue");
    chk("poll_interval", cyc - d, 64);
    chk("poll2_addr", mdio_addr, 5'd17);

    // host write and expired poll both waiting while engine is not ready
    wait_sig(2, 1'b0, "poll2_busy");
    wait_sig(2, 1'b1, "poll2_idle");
    repeat (3) @(negedge clock);
    hold_low = 1'b1;
    host_wr_req = 1'b1; host_addr = 5'd9; host_wr_data = 16'hBEEF;
    bad = 0;
    repeat (80) begin
      @(negedge clock);
      if (mdio_rd_req || mdio_wr_req) bad++;
    end
    chk("no_req_while_not_ready", bad, 0);
    hold_low = 1'b0;
    wait_sig(5, 1'b1, "after_hold_issue");
    chk("host_first_wr", {mdio_wr_req, mdio_rd_req}, 2'b10);
    chk("host_wr_addr", mdio_addr, 5'd9);
    chk("host_wr_data", mdio_wr_data, 16'hBEEF);
    wait_sig(3, 1'b1, "host_wr_ack");
    host_wr_req = 1'b0;
    wait_sig(1, 1'b1, "poll_follows");
    chk("poll_follows_addr", mdio_addr, 5'd17);
    chk("model_reg9", mdl_regs[9], 16'hBEEF);

    // engine never accepts: transaction must time out
    wait_sig(2, 1'b0, "poll3_busy");
    wait_sig(2, 1'b1, "poll3_idle");
    repeat (3) @(negedge clock);
    chk("timeout_err_clear", timeout_err, 0);
    stuck = 1'b1;
    host_rd_req = 1'b1; host_addr = 5'd2;
    wait_sig(1, 1'b1, "to_issue");
    chk("to_addr", mdio_addr, 5'd2);
    n = 0;
    while (mdio_rd_req && n < 400) begin
      n++;
      @(negedge clock);
    end
    chk("to_req_cycles", n, 256);
    chk("to_ack", host_ack, 1);
    chk("to_rd_data", host_rd_data, 16'hFFFF);
    chk("to_err", timeout_err, 1);
    host_rd_req = 1'b0;
    stuck = 1'b0;
    @(negedge clock);
    chk("to_ack_one_cycle", host_ack, 0);

    // reset in BUSY, then init reruns from index 0
    wait_sig(1, 1'b1, "poll4_issue");
    wait_sig(2, 1'b0, "poll4_accept");
    @(negedge clock);
    chk("in_busy", {mdio_rd_req, mdio_ready}, 2'b00);
    reset_n = 1'b0;
    #1;
    chk("rst_busy_reqs", {mdio_rd_req, mdio_wr_req}, 0);
    chk("rst_busy_init_done", init_done, 0);
    chk("rst_busy_status", {status_valid, link_up, timeout_err}, 0);
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    wait_sig(0, 1'b1, "rerun_wr0");
    chk("rerun_wr0_cycle", cyc, 16);
    chk("rerun_wr0_addr", mdio_addr, 5'd0);
    chk("rerun_wr0_data", mdio_wr_data, 16'h1140);
    wait_sig(0, 1'b0, "rerun_wr0_drop");
    wait_sig(0, 1'b1, "rerun_wr1");
    chk("rerun_wr1_addr", mdio_addr, 5'd4);
    chk("addr_stable_in_busy", unstable, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
